// File: rtl/pc_next_unit.sv
// Next-PC selection: sequential, branch, jump, call/return with a small return-address stack.
// Combinational pcnext_out (PC register adds the cycle); no backpressure beyond stall_ctrl holding the PC.
module pc_next_unit #(
    parameter int          STACK_DEPTH = 4,
    parameter logic [15:0] START_ADDR  = 16'h0000,
    localparam int         AW          = $clog2(STACK_DEPTH),
    localparam int         DW          = AW + 1
) (
    input  logic          CLK,
    input  logic          reset_ctrl_n,
    input  logic [15:0]   pc_in,
    input  logic          start_ctrl,
    input  logic          stall_ctrl,
    input  logic          halt_ctrl,
    input  logic          branch_ctrl,
    input  logic          branch_taken_in,
    input  logic [7:0]    offset_in,
    input  logic          jump_ctrl,
    input  logic          call_ctrl,
    input  logic          ret_ctrl,
    input  logic [15:0]   target_in,
    output logic [15:0]   pcnext_out,
    output logic          halted_out,
    output logic          stack_err_out,
    output logic [DW-1:0] depth_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [15:0]   stack_q [STACK_DEPTH];

    logic          push, pop, err_set;
    logic [15:0]   pc_inc, pc_branch, stack_top;
    logic [DW-1:0] top_ptr;
    logic          stack_full, stack_empty;

    assign pc_inc      = pc_in + 16'd1;
    assign pc_branch   = pc_in + {{8{offset_in[7]}}, offset_in};
    assign top_ptr     = depth_q - DW'(1);
    assign stack_top   = stack_q[top_ptr[AW-1:0]];
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

    always_comb begin
        state_d    = state_q;
        pcnext_out = pc_in;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                pcnext_out = START_ADDR;
                if (start_ctrl) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_ctrl) begin
                    state_d = S_HALT;
                end else if (stall_ctrl) begin
                    pcnext_out = pc_in;
                end else if (call_ctrl && ret_ctrl) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else if (ret_ctrl) begin
                    if (!stack_empty) begin
                        pcnext_out = stack_top;
                        pop        = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end
                end else if (call_ctrl) begin
                    // A full stack drops the push and stops rather than corrupting the oldest frame
                    if (!stack_full) begin
                        pcnext_out = target_in;
                        push       = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end
                end else if (jump_ctrl) begin
                    pcnext_out = target_in;
                end else if (branch_ctrl && branch_taken_in) begin
                    pcnext_out = pc_branch;
                end else begin
                    pcnext_out = pc_inc;
                end
            end
            S_HALT: pcnext_out = pc_in;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        depth_d = depth_q;
        if (push)     depth_d = depth_q + DW'(1);
        else if (pop) depth_d = depth_q - DW'(1);
        err_d = err_q | err_set;
    end

    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Entries beyond depth_q are dead, so the array itself needs no reset
    always_ff @(posedge CLK) begin
        if (push) stack_q[depth_q[AW-1:0]] <= pc_inc;
    end

    assign halted_out    = (state_q == S_HALT);
    assign stack_err_out = err_q;
    assign depth_out     = depth_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with hand-computed expected values.
module tb_pc_next_unit;

    logic        CLK = 1'b0;
    logic        reset_ctrl_n;
    logic [15:0] pc_in;
    logic        start_ctrl, stall_ctrl, halt_ctrl, branch_ctrl, branch_taken_in;
    logic [7:0]  offset_in;
    logic        jump_ctrl, call_ctrl, ret_ctrl;
    logic [15:0] target_in;
    logic [15:0] pcnext_out;
    logic        halted_out, stack_err_out;
    logic [2:0]  depth_out;

    int n_vec  = 0;
    int n_miss = 0;

    pc_next_unit #(.STACK_DEPTH(4), .START_ADDR(16'h0000)) dut (
        .CLK             (CLK),
        .reset_ctrl_n    (reset_ctrl_n),
        .pc_in           (pc_in),
        .start_ctrl      (start_ctrl),
        .stall_ctrl      (stall_ctrl),
        .halt_ctrl       (halt_ctrl),
        .branch_ctrl     (branch_ctrl),
        .branch_taken_in (branch_taken_in),
        .offset_in       (offset_in),
        .jump_ctrl       (jump_ctrl),
        .call_ctrl       (call_ctrl),
        .ret_ctrl        (ret_ctrl),
        .target_in       (target_in),
        .pcnext_out      (pcnext_out),
        .halted_out      (halted_out),
        .stack_err_out   (stack_err_out),
        .depth_out       (depth_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        start_ctrl = 0; stall_ctrl = 0; halt_ctrl = 0; branch_ctrl = 0;
        branch_taken_in = 0; offset_in = 8'h00; jump_ctrl = 0;
        call_ctrl = 0; ret_ctrl = 0; target_in = 16'h0000;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rst_start();
        clr();
        reset_ctrl_n = 1'b0; pc_in = 16'h0000;
        tick();
        reset_ctrl_n = 1'b1;
        start_ctrl = 1'b1;
        tick();
        start_ctrl = 1'b0;
    endtask

    task automatic do_call(input logic [15:0] pc, input logic [15:0] tgt, input logic [15:0] exp_depth);
        clr(); pc_in = pc; call_ctrl = 1'b1; target_in = tgt;
        settle();
        chk("call_pcnext", pcnext_out, tgt);
        tick();
        chk("call_depth", {13'd0, depth_out}, exp_depth);
    endtask

    initial begin
        clr();
        pc_in = 16'h0000;
        reset_ctrl_n = 1'b0;
        #2;
        chk("rst_pcnext", pcnext_out, 16'h0000);
        chk("rst_depth", {13'd0, depth_out}, 16'd0);
        chk("rst_halted", {15'd0, halted_out}, 16'd0);
        chk("rst_err", {15'd0, stack_err_out}, 16'd0);
        tick();
        reset_ctrl_n = 1'b1;

        // Idle ignores everything except start
        pc_in = 16'h0055; jump_ctrl = 1'b1; target_in = 16'h1234;
        settle();
        chk("idle_ignore", pcnext_out, 16'h0000);
        tick();
        clr(); pc_in = 16'h0000;
        settle();
        chk("seq0_idle", pcnext_out, 16'h0000);
        start_ctrl = 1'b1;
        settle();
        chk("seq1_start", pcnext_out, 16'h0000);
        tick();
        start_ctrl = 1'b0;
        pc_in = 16'h0000; settle(); chk("seq2", pcnext_out, 16'h0001); tick();
        pc_in = 16'h0001; settle(); chk("seq3", pcnext_out, 16'h0002); tick();
        pc_in = 16'h0002; settle(); chk("seq4", pcnext_out, 16'h0003);
        chk("seq_depth", {13'd0, depth_out}, 16'd0);
        tick();

        // Branch / jump arithmetic
        pc_in = 16'h0010; branch_ctrl = 1'b1; branch_taken_in = 1'b1; offset_in = 8'hF8;
        settle(); chk("br_taken_neg", pcnext_out, 16'h0008);
        branch_taken_in = 1'b0;
        settle(); chk("br_not_taken", pcnext_out, 16'h0011);
        pc_in = 16'h0002; branch_taken_in = 1'b1; offset_in = 8'hFC;
        settle(); chk("br_wrap_neg", pcnext_out, 16'hFFFE);
        pc_in = 16'h0030; offset_in = 8'h7F;
        settle(); chk("br_pos", pcnext_out, 16'h00AF);
        clr(); pc_in = 16'hFFFF;
        settle(); chk("inc_wrap", pcnext_out, 16'h0000);
        pc_in = 16'h0040; jump_ctrl = 1'b1; target_in = 16'h1234; branch_ctrl = 1'b1; branch_taken_in = 1'b1;
        settle(); chk("jump_over_branch", pcnext_out, 16'h1234);

        // Stall beats jump and call; no stack change
        clr(); pc_in = 16'h0077; stall_ctrl = 1'b1; jump_ctrl = 1'b1; call_ctrl = 1'b1; target_in = 16'h5555;
        settle(); chk("stall_pcnext", pcnext_out, 16'h0077);
        tick();
        chk("stall_depth", {13'd0, depth_out}, 16'd0);
        chk("stall_halted", {15'd0, halted_out}, 16'd0);

        // Call then return
        do_call(16'h0020, 16'h0100, 16'd1);
        clr(); pc_in = 16'h0105; ret_ctrl = 1'b1;
        settle(); chk("ret_pcnext", pcnext_out, 16'h0021);
        tick();
        chk("ret_depth", {13'd0, depth_out}, 16'd0);

        // Nesting, LIFO order, overflow
        do_call(16'h0100, 16'h1000, 16'd1);
        do_call(16'h0200, 16'h2000, 16'd2);
        do_call(16'h0300, 16'h3000, 16'd3);
        clr(); pc_in = 16'h3005; ret_ctrl = 1'b1;
        settle(); chk("lifo_top", pcnext_out, 16'h0301);
        tick();
        chk("lifo_depth", {13'd0, depth_out}, 16'd2);
        do_call(16'h0310, 16'h3100, 16'd3);
        do_call(16'h0400, 16'h4000, 16'd4);
        clr(); pc_in = 16'h0500; call_ctrl = 1'b1; target_in = 16'h5000;
        settle(); chk("ovf_pcnext", pcnext_out, 16'h0500);
        tick();
        chk("ovf_err", {15'd0, stack_err_out}, 16'd1);
        chk("ovf_halted", {15'd0, halted_out}, 16'd1);
        chk("ovf_depth", {13'd0, depth_out}, 16'd4);
        clr(); pc_in = 16'h0600; ret_ctrl = 1'b1;
        settle(); chk("halt_ignore", pcnext_out, 16'h0600);
        tick();
        chk("halt_frozen", {13'd0, depth_out}, 16'd4);

        // Asynchronous reset mid-cycle while halted with a populated stack
        #2;
        reset_ctrl_n = 1'b0;
        #1;
        chk("arst_pcnext", pcnext_out, 16'h0000);
        chk("arst_depth", {13'd0, depth_out}, 16'd0);
        chk("arst_err", {15'd0, stack_err_out}, 16'd0);
        chk("arst_halted", {15'd0, halted_out}, 16'd0);

        // Underflow
        rst_start();
        pc_in = 16'h0040; ret_ctrl = 1'b1;
        settle(); chk("unf_pcnext", pcnext_out, 16'h0040);
        tick();
        chk("unf_err", {15'd0, stack_err_out}, 16'd1);
        chk("unf_halted", {15'd0, halted_out}, 16'd1);

        // Call and ret together
        rst_start();
        pc_in = 16'h0060; call_ctrl = 1'b1; ret_ctrl = 1'b1; target_in = 16'h0999;
        settle(); chk("conf_pcnext", pcnext_out, 16'h0060);
        tick();
        chk("conf_err", {15'd0, stack_err_out}, 16'd1);
        chk("conf_halted", {15'd0, halted_out}, 16'd1);
        chk("conf_depth", {13'd0, depth_out}, 16'd0);

        // Explicit halt instruction
        rst_start();
        pc_in = 16'h0070; halt_ctrl = 1'b1; jump_ctrl = 1'b1; target_in = 16'h0888;
        settle(); chk("halt_pcnext", pcnext_out, 16'h0070);
        tick();
        chk("halt_state", {15'd0, halted_out}, 16'd1);
        chk("halt_noerr", {15'd0, stack_err_out}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
